rr_arbiter_fsm: RTL and testbench
=================================

RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting agents (2..16) SHALL be supported.
REQ-002 Parameter MAX_HOLD, default 16, maximum grant length in cycles when timeout is compiled in (1..255) SHALL be supported.
REQ-003 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port mode  input  1  arbitration policy: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-006 Port req  input  NUM_REQ  active-high request, bit i = agent i.
REQ-007 Port gnt  output  NUM_REQ  registered one-hot grant, bit i = agent i.
REQ-008 Port gnt_valid  output  1  registered; high whenever any gnt bit is high.
REQ-009 Port gnt_id  output  clog2(NUM_REQ)  registered index of the granted agent; 0 when gnt_valid low.
REQ-010 Port preempt  output  1  registered one-cycle pulse marking a timeout revocation.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT; any illegal encoding SHALL return to IDLE on the next edge with all outputs low.
REQ-012 In IDLE with req = 0, the block SHALL remain in IDLE with gnt = 0.
REQ-013 In IDLE with req != 0, the block SHALL select one winner and, at the next edge, enter GRANT with the winner's gnt bit, gnt_valid and gnt_id set (latency 1 cycle).
REQ-014 With mode = 0, the winner SHALL be the lowest-indexed requesting agent.
REQ-015 With mode = 1, the search SHALL start at index last+1 and wrap modulo NUM_REQ, where last is the most recently granted agent.
REQ-016 last SHALL update on every grant in both modes.
REQ-017 mode SHALL be sampled only in IDLE; a change during GRANT SHALL take effect at the next arbitration.
REQ-018 In GRANT, the grant SHALL persist while req[owner] = 1, regardless of other requests.
REQ-019 When req[owner] = 0 in GRANT, gnt SHALL be cleared at the next edge and the state SHALL return to IDLE, giving a minimum one-cycle gap between grants.
REQ-020 At most one gnt bit SHALL be high in any cycle.
REQ-021 gnt_id SHALL always equal the index of the set gnt bit.
REQ-022 Requests that rise and fall while another agent holds the grant SHALL NOT be remembered.

Reset
REQ-023 When reset is sampled high, the next edge SHALL clear state to IDLE, gnt, gnt_valid, gnt_id, preempt and the hold counter to 0, and set last to NUM_REQ-1; this SHALL apply even mid-grant.
REQ-024 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN SHALL, when defined, enable a hold counter that increments each GRANT cycle and clears on entering GRANT.
REQ-026 With ARB_TIMEOUT_EN defined, if the hold count reaches MAX_HOLD while another agent requests, the block SHALL clear gnt, pulse preempt for one cycle and return to IDLE.
REQ-027 With ARB_TIMEOUT_EN defined, in the IDLE cycle following a preemption, the preempted agent SHALL be excluded from arbitration if any other agent requests.
REQ-028 With ARB_TIMEOUT_EN defined, if the hold count reaches MAX_HOLD while no other agent requests, the grant SHALL continue and the counter SHALL saturate.
REQ-029 Without ARB_TIMEOUT_EN, no counter SHALL exist, grants SHALL be unbounded and preempt SHALL be tied to 0.

Verification (NUM_REQ=4, MAX_HOLD=4)
REQ-030 Scenario (reset, mode=0): with req=4'b1010 held, gnt SHALL equal 4'b0010 and gnt_id 1 one cycle later; when req[1] drops, gnt SHALL be 0 for 1 cycle, then 4'b1000.
REQ-031 Scenario (mode=1): with req=4'b1111 and each owner releasing after 2 cycles, the grant order SHALL be 0,1,2,3,0.
REQ-032 Scenario (reset mid-grant): asserting reset during GRANT of agent 2 SHALL make all outputs 0 on the next edge, and the first round-robin grant after reset SHALL go to agent 0.
REQ-033 Scenario (ARB_TIMEOUT_EN, mode=0): with req=4'b0011 held, gnt SHALL be 4'b0001 for 4 cycles, then preempt pulses, then one idle cycle, then gnt=4'b0010.
REQ-034 Scenario (ARB_TIMEOUT_EN): with only req[0] held for 10 cycles, gnt SHALL stay 4'b0001 throughout and preempt SHALL stay 0.
REQ-035 Scenario (mode toggle): toggling mode during GRANT SHALL leave the current owner unchanged and apply the new policy at the next arbitration.

Source files
------------

// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: two-state (IDLE/GRANT) request arbiter with registered one-hot grant.
//
// Ports:
//   clock     - sole clock, rising edge
//   reset     - synchronous, active-high reset
//   mode      - 0 = fixed priority (lowest index wins), 1 = round robin after last grant
//   req       - request vector, bit i = agent i
//   gnt       - registered one-hot grant
//   gnt_valid - registered, high while any gnt bit is high
//   gnt_id    - registered index of the granted agent, 0 when no grant
//   preempt   - registered one-cycle pulse marking a timeout revocation
//
// Optional feature: define ARB_TIMEOUT_EN to bound a grant to MAX_HOLD cycles when
// another agent is waiting. Without it grants are unbounded and preempt is tied low.
module rr_arbiter_fsm #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       preempt
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_err
    $error("rr_arbiter_fsm: NUM_REQ or MAX_HOLD out of range");
  end

  // Sparse encoding so an illegal value exists and can be recovered from.
  typedef enum logic [1:0] {
    StIdle  = 2'b01,
    StGrant = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [IdW-1:0]     last_q, last_d;

  logic               owner_req;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] req_masked;
  logic               win_found;
  logic [IdW-1:0]     win_id;

  // Owner still requesting; gnt_q is zero outside GRANT so this is only meaningful there.
  assign owner_req = |(req & gnt_q);

`ifdef ARB_TIMEOUT_EN
  logic               preempt_q, preempt_d;
  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] last_oh;

  assign last_oh     = NUM_REQ'(1) << last_q;
  // hold_q counts completed GRANT cycles, so this cycle is number hold_q + 1.
  assign timeout_hit = owner_req && (|(req & ~gnt_q)) && (hold_q >= 8'(MAX_HOLD - 1));
  assign preempt     = preempt_q;
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  // Winner selection, only consumed in IDLE.
  always_comb begin
    int unsigned    idx;
    logic [IdW-1:0] cand;
    req_masked = req;
`ifdef ARB_TIMEOUT_EN
    // preempt_q marks the IDLE cycle right after a revocation; last_q is the revoked owner.
    if (preempt_q && ((req & ~last_oh) != '0)) begin
      req_masked = req & ~last_oh;
    end
`endif
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = mode ? (32'(last_q) + k + 1) % NUM_REQ : k;
      cand = IdW'(idx);
      if (!win_found && req_masked[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StGrant;
      StGrant: if (!owner_req || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    id_d    = '0;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d   = NUM_REQ'(1) << win_id;
          valid_d = 1'b1;
          id_d    = win_id;
          last_d  = win_id;
        end
      end
      StGrant: begin
        if (owner_req && !timeout_hit) begin
          gnt_d   = gnt_q;
          valid_d = 1'b1;
          id_d    = id_q;
        end
`ifdef ARB_TIMEOUT_EN
        if (timeout_hit) preempt_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  // Cleared while IDLE so it reads 0 on entry to GRANT; saturates at MAX_HOLD.
  always_comb begin
    hold_d = '0;
    if (state_q == StGrant) begin
      hold_d = (hold_q < 8'(MAX_HOLD)) ? hold_q + 8'd1 : hold_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= IdW'(NUM_REQ - 1);
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Testbench for rr_arbiter_fsm (NUM_REQ=4, MAX_HOLD=4): directed scenarios plus random
// traffic, checked cycle by cycle against a queue of predicted outputs.
module tb_rr_arbiter_fsm;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  always #5 clock = ~clock;

  rr_arbiter_fsm #(
    .NUM_REQ (N),
    .MAX_HOLD(MH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mode     (mode),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .preempt  (preempt)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    logic       pre;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: owner = -1 when nobody holds the grant.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_hold  = 0;
  bit m_pre   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit m, input logic [3:0] q);
    logic [3:0] cand;
    int         i;
    if (r) begin
      m_owner = -1;
      m_last  = N - 1;
      m_hold  = 0;
      m_pre   = 1'b0;
    end else if (m_owner < 0) begin
      cand = q;
`ifdef ARB_TIMEOUT_EN
      if (m_pre && ((q & ~(4'(1) << m_last)) != 4'b0)) cand = q & ~(4'(1) << m_last);
`endif
      m_pre = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = m ? (m_last + 1 + k) % N : k;
        if (m_owner < 0 && cand[i]) m_owner = i;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_hold = 0;
      end
    end else begin
      m_pre = 1'b0;
      if (!q[m_owner]) begin
        m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_hold + 1 >= MH && ((q & ~(4'(1) << m_owner)) != 4'b0)) begin
        m_owner = -1;
        m_pre   = 1'b1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
`endif
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, return #1 after the edge.
  task automatic step(input bit r, input bit m, input logic [3:0] q);
    exp_t e;
    @(negedge clock);
    reset = r;
    mode  = m;
    req   = q;
    model_step(r, m, q);
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e.valid = (m_owner >= 0);
    e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
    e.pre   = m_pre;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares the DUT outputs against the oldest prediction.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("scoreboard{gnt,valid,id,pre}", int'({gnt, gnt_valid, gnt_id, preempt}), int'(e));
    end
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] msk;
    bit         md;
    reset = 1'b1;
    mode  = 1'b0;
    req   = 4'b0;

    // Reset state.
    step(1, 0, 4'b0);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_valid_id_pre", int'({gnt_valid, gnt_id, preempt}), 0);

    // Idle with no requests.
    step(0, 0, 4'b0);
    chk("idle_no_req", int'(gnt), 0);

    // Fixed priority, release gap.
    step(0, 0, 4'b1010);
    chk("fp_first_gnt", int'(gnt), 4'b0010);
    chk("fp_first_id", int'(gnt_id), 1);
    step(0, 0, 4'b1010);
    chk("fp_hold_gnt", int'(gnt), 4'b0010);
    step(0, 0, 4'b1000);
    chk("fp_gap_gnt", int'(gnt), 0);
    step(0, 0, 4'b1000);
    chk("fp_next_gnt", int'(gnt), 4'b1000);
    chk("fp_next_id", int'(gnt_id), 3);
    step(0, 0, 4'b0000);

    // Round robin order with owners releasing after two cycles.
    step(1, 1, 4'b0);
    for (int k = 0; k < 5; k++) begin
      msk = 4'hf & ~(4'(1) << (k % N));
      step(0, 1, 4'hf);
      chk("rr_order", int'(gnt), int'(4'(1) << (k % N)));
      step(0, 1, 4'hf);
      step(0, 1, msk);
    end

    // Reset mid-grant; first round-robin grant after reset goes to agent 0.
    step(1, 1, 4'b0);
    step(0, 1, 4'b0100);
    chk("mid_gnt_before_reset", int'(gnt), 4'b0100);
    step(1, 1, 4'b0100);
    chk("mid_reset_outputs", int'({gnt, gnt_valid, gnt_id, preempt}), 0);
    step(0, 1, 4'hf);
    chk("post_reset_rr", int'(gnt), 4'b0001);
    step(0, 1, 4'b0);

    // Mode toggle during GRANT keeps owner; new policy at next arbitration.
    step(1, 0, 4'b0);
    step(0, 0, 4'b0011);
    chk("toggle_owner", int'(gnt), 4'b0001);
    step(0, 1, 4'b0011);
    chk("toggle_keep", int'(gnt), 4'b0001);
    step(0, 1, 4'b0010);
    chk("toggle_gap", int'(gnt), 0);
    step(0, 1, 4'b0011);
    chk("toggle_new_policy", int'(gnt), 4'b0010);
    step(0, 1, 4'b0);

`ifdef ARB_TIMEOUT_EN
    // Timeout preemption with a competing request.
    step(1, 0, 4'b0);
    for (int k = 0; k < MH; k++) begin
      step(0, 0, 4'b0011);
      chk("to_hold", int'(gnt), 4'b0001);
    end
    step(0, 0, 4'b0011);
    chk("to_preempt", int'({gnt, preempt}), 1);
    step(0, 0, 4'b0011);
    chk("to_next", int'({gnt, preempt}), int'({4'b0010, 1'b0}));
    // Lone requester keeps the grant past MAX_HOLD.
    step(1, 0, 4'b0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 4'b0001);
      chk("to_lone", int'({gnt, preempt}), int'({4'b0001, 1'b0}));
    end
`endif

    // Random traffic.
    step(1, 0, 4'b0);
    rq = 4'b0;
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(15) == 0) md = ~md;
      step($urandom_range(127) == 0, md, rq);
    end

    @(negedge clock);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
